issue_arbiter: RTL and testbench

ISSUE_ARBITER -- requirements
Module: issue_arbiter

---
 rtl/issue_arbiter.sv | 137 +++++++++++++
 tb/tb_issue_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/issue_arbiter.sv
// Issue arbiter: grants int/ls/mult/div issue queues against a shared
// common data bus (CDB) reservation shift register.
// Optional divider path is compiled in with `define ISSUE_ARBITER_DIV_EN.
module issue_arbiter #(
  parameter int unsigned LAT_MULT = 4,
  parameter int unsigned LAT_DIV  = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               issueint_ready,
  input  logic               issuels_ready,
  input  logic               issuemult_ready,
  input  logic               issuediv_ready,
  output logic               issueint_done,
  output logic               issuels_done,
  output logic               issuemult_done,
  output logic               issuediv_done,
  output logic [LAT_DIV-1:0] cdb_resv,
  output logic               div_busy
);

  // Round-robin pointer for the int/ls pair sharing CDB slot 1.
  typedef enum logic {
    RR_INT = 1'b0,
    RR_LS  = 1'b1
  } rr_t;

  rr_t               rr;
  rr_t               rr_next;
  logic [LAT_DIV-1:0] resv;
  logic [LAT_DIV-1:0] resv_next;

  logic int_grant;
  logic ls_grant;
  logic mult_grant;
  logic div_grant;
  logic div_busy_int;

  logic slot1_free;
  logic mult_slot_free;

  assign slot1_free     = ~resv[0];
  assign mult_slot_free = ~resv[LAT_MULT-1];

  // int/ls arbitration for slot 1; pointer only moves on real contention.
  always_comb begin
    int_grant = 1'b0;
    ls_grant  = 1'b0;
    rr_next   = rr;
    if (reset_n && slot1_free) begin
      if (issueint_ready && issuels_ready) begin
        if (rr == RR_INT) begin
          int_grant = 1'b1;
          rr_next   = RR_LS;
        end else begin
          ls_grant  = 1'b1;
          rr_next   = RR_INT;
        end
      end else if (issueint_ready) begin
        int_grant = 1'b1;
      end else if (issuels_ready) begin
        ls_grant = 1'b1;
      end
    end
  end

  // Multiplier is fully pipelined: only the CDB slot gates it.
  always_comb begin
    mult_grant = reset_n & issuemult_ready & mult_slot_free;
  end

`ifdef ISSUE_ARBITER_DIV_EN
  logic [3:0] busy_cnt;
  logic       div_slot_free;

  assign div_slot_free = ~resv[LAT_DIV-1];
  assign div_busy_int  = (busy_cnt != '0);

  // Divider grant: unit idle and its far CDB slot unclaimed.
  always_comb begin
    div_grant = reset_n & issuediv_ready & ~div_busy_int & div_slot_free;
  end

  // Non-pipelined divider occupancy counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= '0;
    end else if (div_grant) begin
      busy_cnt <= 4'(LAT_DIV - 1);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 4'd1;
    end
  end
`else
  logic unused_div_ready;

  assign unused_div_ready = issuediv_ready;
  assign div_busy_int     = 1'b0;

  // Divider path not built: never granted.
  always_comb begin
    div_grant = 1'b0;
  end
`endif

  // Reservation shift: every slot moves one cycle closer; a grant of
  // latency L lands at bit L-2 because it is L-1 cycles ahead next cycle.
  // Latency-1 grants need no future reservation.
  always_comb begin
    resv_next = {1'b0, resv[LAT_DIV-1:1]};
    if (mult_grant) begin
      resv_next[LAT_MULT-2] = 1'b1;
    end
    if (div_grant) begin
      resv_next[LAT_DIV-2] = 1'b1;
    end
  end

  // State register for pointer and reservations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr   <= RR_INT;
      resv <= '0;
    end else begin
      rr   <= rr_next;
      resv <= resv_next;
    end
  end

  assign issueint_done  = int_grant;
  assign issuels_done   = ls_grant;
  assign issuemult_done = mult_grant;
  assign issuediv_done  = div_grant;
  assign cdb_resv       = resv;
  assign div_busy       = reset_n & div_busy_int;

endmodule

// File: tb/tb_issue_arbiter.sv
// Scoreboard bench for issue_arbiter: the driver pushes the hand-derived
// expected outputs for each cycle, the monitor pops and compares them.
module tb_issue_arbiter;

`ifdef ISSUE_ARBITER_DIV_EN
  localparam logic D = 1'b1;
`else
  localparam logic D = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       int_ready, ls_ready, mult_ready, div_ready;
  logic       int_done, ls_done, mult_done, div_done;
  logic [6:0] cdb_resv;
  logic       div_busy;

  typedef struct packed {
    logic [3:0] done;   // {int, ls, mult, div}
    logic [6:0] resv;
    logic       busy;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    tests = 0;
  int    fails = 0;

  issue_arbiter #(
    .LAT_MULT(4),
    .LAT_DIV (7)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .issueint_ready (int_ready),
    .issuels_ready  (ls_ready),
    .issuemult_ready(mult_ready),
    .issuediv_ready (div_ready),
    .issueint_done  (int_done),
    .issuels_done   (ls_done),
    .issuemult_done (mult_done),
    .issuediv_done  (div_done),
    .cdb_resv       (cdb_resv),
    .div_busy       (div_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reservation bit b that exists only when the divider is built.
  function automatic logic [6:0] dr(input int b);
    logic [6:0] one;
    one = 7'd1;
    return D ? (one << b) : 7'd0;
  endfunction

  // One cycle of stimulus plus its expected response.
  task automatic cyc(input logic [3:0] rdy, input logic rst,
                     input logic [3:0] ed, input logic [6:0] er,
                     input logic eb, input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    {int_ready, ls_ready, mult_ready, div_ready} = rdy;
    reset_n = rst;
    e.done = ed;
    e.resv = er;
    e.busy = eb;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  initial begin
    exp_t       e;
    string      nm;
    logic [3:0] got;
    logic [3:0] rdy;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        nm  = sb_name.pop_front();
        got = {int_done, ls_done, mult_done, div_done};
        rdy = {int_ready, ls_ready, mult_ready, div_ready};
        tests++;
        if (got !== e.done) begin
          fails++;
          $display("FAIL %s done: got %b expected %b", nm, got, e.done);
        end
        tests++;
        if (cdb_resv !== e.resv) begin
          fails++;
          $display("FAIL %s cdb_resv: got %b expected %b", nm, cdb_resv, e.resv);
        end
        tests++;
        if (div_busy !== e.busy) begin
          fails++;
          $display("FAIL %s div_busy: got %b expected %b", nm, div_busy, e.busy);
        end
        tests++;
        if ((got & ~rdy) !== 4'b0000) begin
          fails++;
          $display("FAIL %s grant_without_ready: done %b ready %b", nm, got, rdy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    int_ready  = 1'b0;
    ls_ready   = 1'b0;
    mult_ready = 1'b0;
    div_ready  = 1'b0;

    // Reset: everything quiet even with all requesters ready.
    cyc(4'b0000, 1'b0, 4'b0000, 7'd0, 1'b0, "rst_idle");
    cyc(4'b1111, 1'b0, 4'b0000, 7'd0, 1'b0, "rst_gate");
    cyc(4'b0000, 1'b1, 4'b0000, 7'd0, 1'b0, "idle");

    // All ready from idle: int, mult, div win; ls loses, pointer moves to ls.
    cyc(4'b1111, 1'b1, {3'b101, D}, 7'd0, 1'b0, "all_rdy");
    // Mult result 3 ahead (bit2), div result 6 ahead (bit5).
    cyc(4'b1100, 1'b1, 4'b0100, 7'b0000100 | dr(5), D, "rr_ls");
    cyc(4'b0000, 1'b1, 4'b0000, 7'b0000010 | dr(4), D, "drain");
    // Mult result next cycle owns slot 1: int must wait.
    cyc(4'b1000, 1'b1, 4'b0000, 7'b0000001 | dr(3), D, "int_blk");
    cyc(4'b1000, 1'b1, 4'b1000, dr(2), D, "int_ok");
    cyc(4'b0001, 1'b1, 4'b0000, dr(1), D, "div_blk");
    // Div result next cycle owns slot 1 only when the divider exists.
    cyc(4'b1000, 1'b1, D ? 4'b0000 : 4'b1000, dr(0), D, "slot_blk");
    cyc(4'b0011, 1'b1, {3'b001, D}, 7'd0, 1'b0, "div_free");
    cyc(4'b1100, 1'b1, 4'b1000, 7'b0000100 | dr(5), D, "mid_op");

    // Reset pulse mid-operation clears reservations and pointer at once.
    cyc(4'b1111, 1'b0, 4'b0000, 7'd0, 1'b0, "rst_pulse");
    cyc(4'b1100, 1'b1, 4'b1000, 7'd0, 1'b0, "post_rst");
    cyc(4'b1100, 1'b1, 4'b0100, 7'd0, 1'b0, "rr_alt1");
    cyc(4'b1100, 1'b1, 4'b1000, 7'd0, 1'b0, "rr_alt2");
    cyc(4'b1100, 1'b1, 4'b0100, 7'd0, 1'b0, "rr_alt3");

    // Mult back to back, then div ready while mult results are in flight.
    cyc(4'b0010, 1'b1, 4'b0010, 7'b0000000, 1'b0, "mult_p0");
    cyc(4'b0010, 1'b1, 4'b0010, 7'b0000100, 1'b0, "mult_p1");
    cyc(4'b0010, 1'b1, 4'b0010, 7'b0000110, 1'b0, "mult_p2");
    cyc(4'b0001, 1'b1, {3'b000, D}, 7'b0000111, 1'b0, "div_far");
    // ls alone still waits for slot 1 to drain.
    cyc(4'b0100, 1'b1, 4'b0000, 7'b0000011 | dr(5), D, "ls_blk1");
    cyc(4'b0100, 1'b1, 4'b0000, 7'b0000001 | dr(4), D, "ls_blk2");
    cyc(4'b0100, 1'b1, 4'b0100, dr(3), D, "ls_ok");
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 1'b1, 4'b0000, dr(2 - i), D, "drain_div");
    end

    // Div held ready: busy for six cycles, regranted on the seventh.
    cyc(4'b0001, 1'b1, {3'b000, D}, 7'd0, 1'b0, "div_b2b0");
    for (int i = 1; i <= 6; i++) begin
      cyc(4'b0001, 1'b1, 4'b0000, dr(6 - i), D, "div_busy");
    end
    cyc(4'b0001, 1'b1, {3'b000, D}, 7'd0, 1'b0, "div_b2b7");
    cyc(4'b0000, 1'b1, 4'b0000, dr(5), D, "div_b2b8");

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
